// File: rtl/nibble_serial_adder.sv
// Serial adder: processes one 4-bit slice of A+B+Cin per clock, LSB first,
// and publishes the full sum with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one slice per edge, slice index 0..NIBBLES-1
// DONE  | result valid, done pulse; returns to IDLE next edge
module nibble_serial_adder #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Cout
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q, sum_q, sum_nx;
    logic          carry;
    logic [IW-1:0] idx;
    logic [4:0]    slice;
    logic          accept, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The carry register is the only link between slices.
    always_comb begin
        slice  = {1'b0, a_q[idx*4 +: 4]} + {1'b0, b_q[idx*4 +: 4]} + {4'b0000, carry};
        sum_nx = sum_q;
        sum_nx[idx*4 +: 4] = slice[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                carry <= Cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum_q <= sum_nx;
                carry <= slice[4];
                idx   <= idx + 1'b1;
                if (last) begin
                    S    <= sum_nx;
                    Cout <= slice[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at NIBBLES=4:
// results, fixed latency, busy width, held start, and mid-operation reset.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A, B;
    logic        Cin;
    logic        busy, done;
    logic [15:0] S;
    logic        Cout;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation from IDLE and samples 1ns after edges E0..E0+5.
    // hold=1 keeps start high and changes A during RUN/DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input bit hold,
                          output logic [15:0] s, output logic co, output int lat,
                          output int bcnt, output int dcnt, output bit hold_ok,
                          output bit idle_end);
        logic [15:0] ps;
        logic        pc;
        ps = S;
        pc = Cout;
        A = a; B = b; Cin = ci; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0; A = ~a; B = ~b; Cin = ~ci;
        end else begin
            A = 16'hAAAA;
        end
        lat = -1; bcnt = 0; dcnt = 0; hold_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = k;
            end
            if (k < 4 && (S !== ps || Cout !== pc)) hold_ok = 1'b0;
        end
        idle_end = !busy;
        s  = S;
        co = Cout;
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input bit hold,
                            input logic [15:0] es, input logic ec);
        logic [15:0] s;
        logic        co;
        int          lat, bcnt, dcnt;
        bit          hold_ok, idle_end;
        run_op(a, b, ci, hold, s, co, lat, bcnt, dcnt, hold_ok, idle_end);
        check({name, ".S"}, 32'(s), 32'(es));
        check({name, ".Cout"}, 32'(co), 32'(ec));
        check({name, ".latency"}, lat, 4);
        check({name, ".busy_cycles"}, bcnt, 5);
        check({name, ".done_count"}, dcnt, 1);
        check({name, ".S_held_in_run"}, 32'(hold_ok), 32'd1);
        check({name, ".idle_after"}, 32'(idle_end), 32'd1);
    endtask

    initial begin
        int          dseen;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rsum;

        tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
        tbl[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #3;
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.S", 32'(S), 0);
        check("reset.Cout", 32'(Cout), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0,
                     tbl[i].s, tbl[i].cout);

        // Held start: only one result, the next acceptance happens from IDLE with A=AAAA.
        check_op("hold", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0);
        check_op("after_hold", 16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'hBBBB, 1'b0);

        // Reset during the second RUN cycle.
        A = 16'h5555; B = 16'h0001; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midreset.busy", 32'(busy), 0);
        check("midreset.done", 32'(done), 0);
        check("midreset.S", 32'(S), 0);
        check("midreset.Cout", 32'(Cout), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dseen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) dseen++;
        end
        check("midreset.no_activity", dseen, 0);
        check_op("post_reset", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);

        // Back-to-back random operations.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            check_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, rsum[15:0], rsum[16]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
